// File: rtl/sobel_tx_serial.sv
// sobel_tx_serial
// UART 8N1 transmitter answering the Sobel control unit's tx handshake.
// On an accepted tx_partida it latches one byte from the output buffer and
// shifts it out LSB first on saida_serial, then pulses tx_pronto for one cycle.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous, active-high
//   tx_enable     gates acceptance of tx_partida
//   tx_partida    start request, sampled every cycle
//   dados         byte to send, sampled on the accepting edge only
//   saida_serial  UART line, idle high
//   tx_pronto     one-cycle pulse when the frame is complete
//   ocupado       high while a frame is in flight
//   db_estado     debug state code (0..5, 4'hE for an illegal encoding)
module sobel_tx_serial #(
    parameter int unsigned BAUD_DIV  = 434,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic                 tx_partida,
    input  logic [DATA_BITS-1:0] dados,
    output logic                 saida_serial,
    output logic                 tx_pronto,
    output logic                 ocupado,
    output logic [3:0]           db_estado
);

    localparam int unsigned BaudW = $clog2(BAUD_DIV);
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StInicial = 3'd0,
        StEspera  = 3'd1,
        StInicio  = 3'd2,
        StDados   = 3'd3,
        StParada  = 3'd4,
        StFinal   = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [BaudW-1:0]       baud_q, baud_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   baud_tick;

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StInicial;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign baud_tick = (baud_q == BaudLast);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        case (state_q)
            StInicial: begin
                state_d = StEspera;
                baud_d  = '0;
                bit_d   = '0;
            end
            StEspera: begin
                if (tx_enable && tx_partida) begin
                    state_d = StInicio;
                    shift_d = dados;
                    baud_d  = '0;
                end
            end
            StInicio: begin
                if (baud_tick) begin
                    state_d = StDados;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StDados: begin
                if (baud_tick) begin
                    baud_d = '0;
                    // Fill with ones so the register drains to the idle level
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = 1'b1;
                    if (bit_q == BitLast) begin
                        state_d = StParada;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StParada: begin
                if (baud_tick) begin
                    state_d = StFinal;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StFinal: begin
                state_d = StEspera;
            end
            default: begin
                state_d = StInicial;
                baud_d  = '0;
                bit_d   = '0;
                shift_d = '1;
            end
        endcase
    end

    // Moore outputs decoded from state
    always_comb begin
        saida_serial = 1'b1;
        tx_pronto    = 1'b0;
        ocupado      = 1'b0;
        db_estado    = 4'hE;

        case (state_q)
            StInicial: db_estado = 4'h0;
            StEspera:  db_estado = 4'h1;
            StInicio: begin
                db_estado    = 4'h2;
                saida_serial = 1'b0;
                ocupado      = 1'b1;
            end
            StDados: begin
                db_estado    = 4'h3;
                saida_serial = shift_q[0];
                ocupado      = 1'b1;
            end
            StParada: begin
                db_estado = 4'h4;
                ocupado   = 1'b1;
            end
            StFinal: begin
                db_estado = 4'h5;
                ocupado   = 1'b1;
                tx_pronto = 1'b1;
            end
            default: db_estado = 4'hE;
        endcase
    end

endmodule

// File: tb/tb_sobel_tx_serial.sv
// Bench for sobel_tx_serial with BAUD_DIV=4, DATA_BITS=8.
// Reference model tracks the frame as an offset from the accepting edge and
// derives the line level from the bit index of that offset.
module tb_sobel_tx_serial;

    localparam int unsigned B     = 4;
    localparam int unsigned N     = 8;
    localparam int          FRAME = 10 * B;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_enable;
    logic       tx_partida;
    logic [7:0] dados;
    logic       saida_serial;
    logic       tx_pronto;
    logic       ocupado;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    sobel_tx_serial #(
        .BAUD_DIV  (B),
        .DATA_BITS (N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tx_enable    (tx_enable),
        .tx_partida   (tx_partida),
        .dados        (dados),
        .saida_serial (saida_serial),
        .tx_pronto    (tx_pronto),
        .ocupado      (ocupado),
        .db_estado    (db_estado)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pronto_cnt = 0;
    int ocupado_cnt = 0;

    // Reference model: m_init = cycle right after reset; m_off = cycles since accept
    bit         m_init = 1'b1;
    int         m_off  = 0;
    logic [7:0] m_byte = 8'h00;

    typedef struct {
        logic       rst;
        logic       en;
        logic       par;
        logic [7:0] d;
        int         cycles;
        logic [3:0] exp_db;
        logic       exp_ocu;
    } vec_t;

    vec_t vt[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic exp_line();
        int idx;
        if (m_init || m_off == 0 || m_off > FRAME) return 1'b1;
        idx = (m_off - 1) / B;
        if (idx == 0) return 1'b0;
        if (idx <= N) return m_byte[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [3:0] exp_db();
        if (m_init) return 4'h0;
        if (m_off == 0) return 4'h1;
        if (m_off <= B) return 4'h2;
        if (m_off <= (N + 1) * B) return 4'h3;
        if (m_off <= FRAME) return 4'h4;
        return 4'h5;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_init = 1'b1;
            m_off  = 0;
        end else if (m_init) begin
            m_init = 1'b0;
        end else if (m_off == FRAME + 1) begin
            m_off = 0;
        end else if (m_off > 0) begin
            m_off++;
        end else if (tx_enable && tx_partida) begin
            m_off  = 1;
            m_byte = dados;
        end
    endtask

    // One clock: update model on the edge, compare all outputs 1 time unit later
    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        check("saida_serial", 32'(saida_serial), 32'(exp_line()));
        check("ocupado", 32'(ocupado), 32'(!m_init && m_off != 0));
        check("tx_pronto", 32'(tx_pronto), 32'(!m_init && m_off == FRAME + 1));
        check("db_estado", 32'(db_estado), 32'(exp_db()));
        if (tx_pronto === 1'b1) pronto_cnt++;
        if (ocupado === 1'b1) ocupado_cnt++;
    endtask

    initial begin
        logic [9:0] pat;
        int p1;
        int c1;

        reset      = 1'b1;
        tx_enable  = 1'b0;
        tx_partida = 1'b0;
        dados      = 8'h00;

        // Reset / idle / gated-request table
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 2, 4'h0, 1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 10, 4'h1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 8'h55, 12, 4'h1, 1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 8'h11, 3, 4'h1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            reset      = vt[i].rst;
            tx_enable  = vt[i].en;
            tx_partida = vt[i].par;
            dados      = vt[i].d;
            for (int c = 0; c < vt[i].cycles; c++) step();
            check("vec_db", 32'(db_estado), 32'(vt[i].exp_db));
            check("vec_ocupado", 32'(ocupado), 32'(vt[i].exp_ocu));
            check("vec_line", 32'(saida_serial), 32'd1);
        end

        // Frame 0xA5: fixed expected line pattern, LSB first
        pat        = 10'b1101001010;
        tx_enable  = 1'b1;
        dados      = 8'hA5;
        tx_partida = 1'b1;
        step();
        tx_partida = 1'b0;
        for (int i = 1; i <= FRAME + 1; i++) begin
            if (i > 1) step();
            if (i <= FRAME) check("a5_line", 32'(saida_serial), 32'(pat[(i-1)/B]));
            check("a5_pronto", 32'(tx_pronto), 32'(i == FRAME + 1));
        end
        step();

        // Held request: back-to-back frames 0x00 then 0xFF
        pronto_cnt = 0;
        p1         = -1;
        c1         = -1;
        dados      = 8'h00;
        tx_partida = 1'b1;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            step();
            if (i == 0) dados = 8'hFF;
            if (tx_pronto === 1'b1 && p1 < 0) p1 = cyc;
            if (p1 >= 0 && c1 < 0 && cyc > p1 && saida_serial === 1'b0) c1 = cyc;
        end
        tx_partida = 1'b0;
        step();
        step();
        check("b2b_gap", 32'(c1 - p1), 32'd2);
        check("b2b_prontos", 32'(pronto_cnt), 32'd2);

        // Mid-frame request ignored
        pronto_cnt = 0;
        dados      = 8'($urandom);
        tx_partida = 1'b1;
        step();
        tx_partida = 1'b0;
        for (int i = 0; i < 10; i++) step();
        dados      = 8'h3C;
        tx_partida = 1'b1;
        step();
        tx_partida = 1'b0;
        for (int i = 0; i < 35; i++) step();
        check("mid_prontos", 32'(pronto_cnt), 32'd1);

        // Reset in the middle of a frame
        pronto_cnt = 0;
        dados      = 8'($urandom);
        tx_partida = 1'b1;
        step();
        tx_partida = 1'b0;
        for (int i = 0; i < 14; i++) step();
        reset = 1'b1;
        step();
        check("rst_db", 32'(db_estado), 32'd0);
        check("rst_line", 32'(saida_serial), 32'd1);
        check("rst_ocupado", 32'(ocupado), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 45; i++) step();
        check("rst_no_pronto", 32'(pronto_cnt), 32'd0);
        dados      = 8'($urandom);
        tx_partida = 1'b1;
        step();
        tx_partida = 1'b0;
        for (int i = 0; i < FRAME + 2; i++) step();
        check("rst_new_frame", 32'(pronto_cnt), 32'd1);

        // tx_enable low blocks starts; dropping it mid-frame lets the frame finish
        ocupado_cnt = 0;
        tx_enable   = 1'b0;
        tx_partida  = 1'b1;
        dados       = 8'($urandom);
        for (int i = 0; i < 20; i++) step();
        check("en_low_idle", 32'(ocupado_cnt), 32'd0);
        tx_enable = 1'b1;
        step();
        for (int i = 1; i < 20; i++) step();
        tx_enable = 1'b0;
        for (int i = 20; i < FRAME + 1; i++) step();
        check("en_drop_pronto", 32'(tx_pronto), 32'd1);
        ocupado_cnt = 0;
        for (int i = 0; i < 20; i++) step();
        check("en_drop_no_start", 32'(ocupado_cnt), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            tx_enable  = ($urandom_range(0, 3) != 0);
            tx_partida = 1'($urandom_range(0, 1));
            dados      = 8'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
